// File: rtl/grom_uart_tx_if.sv
// grom_uart_tx_if: grom8 CPU I/O bus as seen by the UART transmitter.
// The master modport is the CPU side; the slave modport is the peripheral side.
interface grom_uart_tx_if;
    logic [11:0] addr;
    logic [7:0]  data_in;
    logic        we;
    logic        ioreq;
    logic [7:0]  data_out;
    logic        io_hit;

    modport master (
        output addr,
        output data_in,
        output we,
        output ioreq,
        input  data_out,
        input  io_hit
    );

    modport slave (
        input  addr,
        input  data_in,
        input  we,
        input  ioreq,
        output data_out,
        output io_hit
    );
endinterface

// File: rtl/grom_uart_tx.sv
// grom_uart_tx: memory-mapped 8N1 serial transmitter on the grom8 I/O bus.
// Define GROM_UART_FIFO_EN for a 4-entry transmit FIFO; otherwise a single holding register is used.
module grom_uart_tx #(
    parameter int unsigned CLK_DIV   = 16,
    parameter logic [7:0]  BASE_ADDR = 8'h00
) (
    input  logic          clk,
    input  logic          reset,
    grom_uart_tx_if.slave bus,
    output logic          tx,
    output logic          busy
);
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    logic       w_sel;
    logic       w_rd;
    logic       w_wrStrobe;
    logic       w_wrData;
    logic       w_push;
    logic       w_drop;
    logic       w_pop;
    logic       w_stRead;
    logic       w_ovfClr;
    logic       w_empty;
    logic       w_full;
    logic       w_bitEnd;
    logic [2:0] w_count;
    logic [7:0] w_head;
    logic [7:0] w_status;
    logic [7:0] w_rdData;

    logic       r_weD;
    logic       r_stRdD;
    logic       r_ovf;
    logic [7:0] r_dataOut;
    logic       r_ioHit;

    state_t     r_state;
    logic [7:0] r_baud;
    logic [7:0] r_shift;
    logic [2:0] r_bitIdx;
    logic       r_tx;
    logic       r_busy;

    // Bit 0 of the address selects the register, so only bits 7:1 take part in the match.
    assign w_sel      = bus.ioreq & (bus.addr[7:1] == BASE_ADDR[7:1]);
    assign w_rd       = w_sel & ~bus.we;
    assign w_wrStrobe = w_sel & bus.we & ~r_weD;
    assign w_wrData   = w_wrStrobe & ~bus.addr[0];
    assign w_push     = w_wrData & ~w_full;
    assign w_drop     = w_wrData & w_full;
    assign w_stRead   = w_rd & bus.addr[0];
    assign w_ovfClr   = w_stRead & ~r_stRdD;
    assign w_bitEnd   = (r_baud == 8'd0);
    assign w_pop      = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_bitEnd));

`ifdef GROM_UART_FIFO_EN
    logic [7:0] r_mem [4];
    logic [1:0] r_wrPtr;
    logic [1:0] r_rdPtr;
    logic [2:0] r_count;

    // Two-bit pointers wrap naturally over the four entries; count runs 0..4.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= 2'd0;
            r_rdPtr <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 2'd1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= bus.data_in;
        end
    end

    assign w_count = r_count;
    assign w_empty = (r_count == 3'd0);
    assign w_full  = (r_count == 3'd4);
    assign w_head  = r_mem[r_rdPtr];
`else
    logic [7:0] r_hold;
    logic       r_holdValid;

    // Push only happens when empty and pop only when full, so they never coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold      <= 8'h00;
            r_holdValid <= 1'b0;
        end else if (w_push) begin
            r_hold      <= bus.data_in;
            r_holdValid <= 1'b1;
        end else if (w_pop) begin
            r_holdValid <= 1'b0;
        end
    end

    assign w_count = {2'b00, r_holdValid};
    assign w_empty = ~r_holdValid;
    assign w_full  = r_holdValid;
    assign w_head  = r_hold;
`endif

    assign w_status = {4'b0000, r_ovf, w_empty, w_full, r_busy};
    assign w_rdData = bus.addr[0] ? w_status : {5'b00000, w_count};

    // Bus side: write edge detect, sticky overflow, registered read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_weD     <= 1'b0;
            r_stRdD   <= 1'b0;
            r_ovf     <= 1'b0;
            r_dataOut <= 8'h00;
            r_ioHit   <= 1'b0;
        end else begin
            r_weD   <= w_sel & bus.we;
            r_stRdD <= w_stRead;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovfClr) begin
                r_ovf <= 1'b0;
            end
            r_dataOut <= w_rd ? w_rdData : 8'h00;
            r_ioHit   <= w_rd;
        end
    end

    // Shifter: STOP pops directly into START so consecutive frames have no idle gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_baud   <= 8'd0;
            r_shift  <= 8'h00;
            r_bitIdx <= 3'd0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_baud  <= DIV_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bitEnd) begin
                        r_tx     <= r_shift[0];
                        r_bitIdx <= 3'd0;
                        r_baud   <= DIV_LOAD;
                        r_state  <= DATA;
                    end else begin
                        r_baud <= r_baud - 8'd1;
                    end
                end
                DATA: begin
                    if (w_bitEnd) begin
                        r_baud <= DIV_LOAD;
                        if (r_bitIdx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_tx     <= r_shift[1];
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_bitIdx <= r_bitIdx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - 8'd1;
                    end
                end
                STOP: begin
                    if (w_bitEnd) begin
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_baud  <= DIV_LOAD;
                            r_state <= START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx           = r_tx;
    assign busy         = r_busy;
    assign bus.data_out = r_dataOut;
    assign bus.io_hit   = r_ioHit;
endmodule

// File: tb/tb_grom_uart_tx.sv
// tb_grom_uart_tx: directed self-checking bench for grom_uart_tx with CLK_DIV=4, BASE_ADDR=8'h40.
// Expectations adapt to GROM_UART_FIFO_EN the same way the design does.
module tb_grom_uart_tx;
    localparam int         CLK_DIV = 4;
    localparam logic [7:0] BASE    = 8'h40;

`ifdef GROM_UART_FIFO_EN
    localparam logic [7:0] ST_ONE_QUEUED = 8'h01;
    localparam logic [7:0] FULL_COUNT    = 8'h04;
`else
    localparam logic [7:0] ST_ONE_QUEUED = 8'h03;
    localparam logic [7:0] FULL_COUNT    = 8'h01;
`endif

    logic clk = 1'b0;
    logic reset;
    logic tx;
    logic busy;
    int   checks   = 0;
    int   failures = 0;

    grom_uart_tx_if bus();

    grom_uart_tx #(
        .CLK_DIV   (CLK_DIV),
        .BASE_ADDR (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ioreq, input logic we, input logic [11:0] addr, input logic [7:0] data);
        bus.ioreq   = ioreq;
        bus.we      = we;
        bus.addr    = addr;
        bus.data_in = data;
    endtask

    task automatic writeReg(input logic [11:0] addr, input logic [7:0] data);
        applyStimulus(1'b1, 1'b1, addr, data);
        tick();
        applyStimulus(1'b0, 1'b0, 12'h000, 8'h00);
    endtask

    task automatic readReg(input logic [11:0] addr, output logic [7:0] data, output logic hit);
        applyStimulus(1'b1, 1'b0, addr, 8'h00);
        tick();
        data = bus.data_out;
        hit  = bus.io_hit;
        applyStimulus(1'b0, 1'b0, 12'h000, 8'h00);
    endtask

    // k counts clocks from the edge that pops the byte: 4 start, 32 data, 4 stop.
    function automatic logic expTx(input logic [7:0] b, input int k);
        if (k < 4)
            return 1'b0;
        else if (k < 36)
            return b[(k - 4) / 4];
        else
            return 1'b1;
    endfunction

    task automatic checkFrame(input logic [7:0] b, input int kFrom, input int kTo);
        for (int k = kFrom; k <= kTo; k++) begin
            tick();
            checkOutput($sformatf("tx_%02h_k%0d", b, k), {7'b0, tx}, {7'b0, expTx(b, k)});
            checkOutput($sformatf("busy_%02h_k%0d", b, k), {7'b0, busy}, 8'h01);
        end
    endtask

    initial begin
        logic [7:0] rdData;
        logic       rdHit;
        int         waitCnt;
        int         lowCnt;

        $display("[TB] reset and idle state");
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 12'h000, 8'h00);
        repeat (3) tick();
        checkOutput("rst_tx", {7'b0, tx}, 8'h01);
        checkOutput("rst_busy", {7'b0, busy}, 8'h00);
        checkOutput("rst_data_out", bus.data_out, 8'h00);
        checkOutput("rst_io_hit", {7'b0, bus.io_hit}, 8'h00);
        reset = 1'b1;
        tick();
        readReg(12'hF41, rdData, rdHit);
        checkOutput("status_after_reset", rdData, 8'h04);
        checkOutput("status_hit", {7'b0, rdHit}, 8'h01);
        tick();
        checkOutput("hit_drops", {7'b0, bus.io_hit}, 8'h00);
        checkOutput("data_out_zero_idle", bus.data_out, 8'h00);

        $display("[TB] single frame 0x55");
        writeReg(12'h040, 8'h55);
        checkOutput("pre_pop_tx", {7'b0, tx}, 8'h01);
        checkOutput("pre_pop_busy", {7'b0, busy}, 8'h00);
        checkFrame(8'h55, 0, 39);
        tick();
        checkOutput("frame55_busy_end", {7'b0, busy}, 8'h00);
        checkOutput("frame55_tx_end", {7'b0, tx}, 8'h01);

        $display("[TB] back-to-back frames 0xA0, 0x0F");
        writeReg(12'h040, 8'hA0);
        tick();
        checkOutput("a0_start_tx", {7'b0, tx}, 8'h00);
        writeReg(12'h040, 8'h0F);
        readReg(12'h041, rdData, rdHit);
        checkOutput("status_one_queued", rdData, ST_ONE_QUEUED);
        checkFrame(8'hA0, 3, 39);
        checkFrame(8'h0F, 0, 39);
        tick();
        checkOutput("b2b_busy_end", {7'b0, busy}, 8'h00);

        $display("[TB] overflow with six writes");
        writeReg(12'h040, 8'h11);
        for (int i = 0; i < 5; i++) begin
            tick();
            writeReg(12'h040, 8'h22 + 8'(i));
        end
        readReg(12'h041, rdData, rdHit);
        checkOutput("status_ovf", rdData, 8'h0B);
        tick();
        readReg(12'h041, rdData, rdHit);
        checkOutput("status_ovf_cleared", rdData, 8'h03);
        readReg(12'h040, rdData, rdHit);
        checkOutput("occupancy_full", rdData, FULL_COUNT);
        checkOutput("occupancy_hit", {7'b0, rdHit}, 8'h01);
        waitCnt = 0;
        while (busy && waitCnt < 400) begin
            tick();
            waitCnt++;
        end
        checkOutput("drain_busy", {7'b0, busy}, 8'h00);
        readReg(12'h041, rdData, rdHit);
        checkOutput("status_drained", rdData, 8'h04);

        $display("[TB] ignored cycles");
        applyStimulus(1'b0, 1'b1, 12'h040, 8'hAA);
        tick();
        checkOutput("noreq_hit", {7'b0, bus.io_hit}, 8'h00);
        applyStimulus(1'b0, 1'b0, 12'h000, 8'h00);
        repeat (2) tick();
        checkOutput("noreq_busy", {7'b0, busy}, 8'h00);
        checkOutput("noreq_tx", {7'b0, tx}, 8'h01);
        writeReg(12'h042, 8'hAA);
        checkOutput("offwin_write_hit", {7'b0, bus.io_hit}, 8'h00);
        readReg(12'h042, rdData, rdHit);
        checkOutput("offwin_read_data", rdData, 8'h00);
        checkOutput("offwin_read_hit", {7'b0, rdHit}, 8'h00);
        writeReg(12'h041, 8'hFF);
        repeat (3) tick();
        checkOutput("status_write_busy", {7'b0, busy}, 8'h00);
        checkOutput("status_write_tx", {7'b0, tx}, 8'h01);
        readReg(12'h041, rdData, rdHit);
        checkOutput("status_after_ignored", rdData, 8'h04);

        $display("[TB] reset during bit 3");
        writeReg(12'h040, 8'h04);
        tick();
        writeReg(12'h040, 8'h33);
        checkFrame(8'h04, 2, 17);
        checkOutput("bit3_low", {7'b0, tx}, 8'h00);
        reset = 1'b0;
        #1;
        checkOutput("async_rst_tx", {7'b0, tx}, 8'h01);
        checkOutput("async_rst_busy", {7'b0, busy}, 8'h00);
        repeat (2) tick();
        reset = 1'b1;
        readReg(12'h041, rdData, rdHit);
        checkOutput("status_after_midrst", rdData, 8'h04);
        lowCnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!tx || busy)
                lowCnt++;
        end
        checkOutput("no_frame_after_rst", 8'(lowCnt), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
